// File: rtl/tdm_fir_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tdm_fir_pkg : FSM states, width helpers and output round/saturate        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package tdm_fir_pkg;

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_IDLE = 3'd1,
    ST_MAC  = 3'd2,
    ST_RND  = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int tap_cnt);
    return data_w + coef_w + $clog2(tap_cnt);
  endfunction

  // Round half up from Q(COEF_W-1), then clamp to the signed OUT_W range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int coef_w, input int out_w);
    logic signed [63:0] y, hi, lo;
    y  = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_fir_bank_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tdm_fir_bank_if : sample, result and coefficient-load signals            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface tdm_fir_bank_if #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int TAP_CNT = 31,
  parameter int CH_CNT  = 4,
  parameter int GAIN_W  = 4
);
  localparam int CH_W  = tdm_fir_pkg::width_of(CH_CNT);
  localparam int TAP_W = tdm_fir_pkg::width_of(TAP_CNT);
  localparam int OUT_W = DATA_W + GAIN_W;

  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic signed [OUT_W-1:0]  out_data;
  logic                     coef_we;
  logic [TAP_W-1:0]         coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_swap;
  logic                     err_ch;

  modport master (
    output in_valid, in_ch, in_data, out_ready, coef_we, coef_addr, coef_data, coef_swap,
    input  in_ready, out_valid, out_ch, out_data, err_ch
  );

  modport slave (
    input  in_valid, in_ch, in_data, out_ready, coef_we, coef_addr, coef_data, coef_swap,
    output in_ready, out_valid, out_ch, out_data, err_ch
  );
endinterface
`default_nettype wire

// File: rtl/tdm_fir_bank_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tdm_fir_mac : registered signed MAC with clear/enable and rounded output |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tdm_fir_mac
  import tdm_fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 37,
  parameter int OUT_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] c_i,
  output logic signed [OUT_W-1:0]  y_o
);
  logic signed [DATA_W+COEF_W-1:0] prod_d;
  logic signed [ACC_W-1:0]         acc_q;

  assign prod_d = x_i * c_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_W'(prod_d);
    end
  end

  assign y_o = OUT_W'(sat_round(64'(acc_q), COEF_W, OUT_W));
endmodule
`default_nettype wire

// File: rtl/tdm_fir_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tdm_fir_bank : CH_CNT-channel FIR sharing one MAC, double-buffered coefs |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tdm_fir_bank
  import tdm_fir_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int TAP_CNT = 31,
  parameter int CH_CNT  = 4,
  parameter int GAIN_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  tdm_fir_bank_if.slave  bus
);
  localparam int CH_W      = width_of(CH_CNT);
  localparam int TAP_W     = width_of(TAP_CNT);
  localparam int ACC_W     = acc_width(DATA_W, COEF_W, TAP_CNT);
  localparam int OUT_W     = DATA_W + GAIN_W;
  localparam int MEM_DEPTH = CH_CNT * TAP_CNT;
  localparam int MEM_W     = width_of(MEM_DEPTH);

  state_e                   state_q, state_d;
  logic [MEM_W-1:0]         clr_cnt_q;
  logic [TAP_W-1:0]         tap_q;
  logic [CH_W-1:0]          ch_q;
  logic [TAP_W-1:0]         head_q [CH_CNT];
  logic signed [COEF_W-1:0] shadow_q [TAP_CNT];
  logic signed [COEF_W-1:0] active_q [TAP_CNT];
  logic signed [DATA_W-1:0] hist_q [MEM_DEPTH];
  logic                     swap_pend_q, out_valid_q, err_ch_q;
  logic [CH_W-1:0]          out_ch_q;
  logic signed [OUT_W-1:0]  out_data_q;

  logic                     ch_ok_d, accept_d, drop_d, copy_d, mac_en_d, load_out_d, release_d;
  logic [TAP_W-1:0]         idx_d;
  logic [MEM_W-1:0]         rd_addr_d, wr_addr_d;
  logic                     mem_we_d;
  logic signed [DATA_W-1:0] mem_wdata_d;
  logic signed [OUT_W-1:0]  y_d;

  assign ch_ok_d = (int'(bus.in_ch) < CH_CNT);

  always_comb begin
    state_d    = state_q;
    accept_d   = 1'b0;
    drop_d     = 1'b0;
    copy_d     = 1'b0;
    mac_en_d   = 1'b0;
    load_out_d = 1'b0;
    release_d  = 1'b0;
    case (state_q)
      ST_CLR: begin
        if (clr_cnt_q == MEM_W'(MEM_DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        copy_d = swap_pend_q;
        if (bus.in_valid) begin
          if (ch_ok_d) begin
            accept_d = 1'b1;
            state_d  = ST_MAC;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_MAC: begin
        mac_en_d = 1'b1;
        if (tap_q == TAP_W'(TAP_CNT - 1)) state_d = ST_RND;
      end
      ST_RND: begin
        load_out_d = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          release_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_CLR;
    endcase
  end

  // Tap k reads x[n-k], wrapping backwards through the channel's ring.
  always_comb begin
    if (head_q[ch_q] >= tap_q) idx_d = head_q[ch_q] - tap_q;
    else                       idx_d = TAP_W'(int'(head_q[ch_q]) + TAP_CNT - int'(tap_q));
    rd_addr_d   = MEM_W'(int'(ch_q) * TAP_CNT + int'(idx_d));
    mem_we_d    = (state_q == ST_CLR) || accept_d;
    wr_addr_d   = (state_q == ST_CLR) ? clr_cnt_q
                                      : MEM_W'(int'(bus.in_ch) * TAP_CNT + int'(head_q[bus.in_ch]));
    mem_wdata_d = (state_q == ST_CLR) ? '0 : bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) hist_q[wr_addr_d] <= mem_wdata_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAP_CNT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (copy_d) begin
        for (int i = 0; i < TAP_CNT; i++) active_q[i] <= shadow_q[i];
      end
      if (bus.coef_we && (int'(bus.coef_addr) < TAP_CNT)) shadow_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLR;
      clr_cnt_q   <= '0;
      tap_q       <= '0;
      ch_q        <= '0;
      swap_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      err_ch_q    <= 1'b0;
      for (int c = 0; c < CH_CNT; c++) head_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= (state_q == ST_CLR) ? clr_cnt_q + 1'b1 : '0;
      err_ch_q    <= drop_d;
      swap_pend_q <= bus.coef_swap | (swap_pend_q & ~copy_d);
      if (accept_d) begin
        ch_q  <= bus.in_ch;
        tap_q <= '0;
      end else if (mac_en_d) begin
        tap_q <= tap_q + 1'b1;
      end
      if (load_out_d) begin
        out_valid_q  <= 1'b1;
        out_ch_q     <= ch_q;
        out_data_q   <= y_d;
        head_q[ch_q] <= (head_q[ch_q] == TAP_W'(TAP_CNT - 1)) ? '0 : head_q[ch_q] + 1'b1;
      end else if (release_d) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  tdm_fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept_d),
    .en_i  (mac_en_d),
    .x_i   (hist_q[rd_addr_d]),
    .c_i   (active_q[tap_q]),
    .y_o   (y_d)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.err_ch    = err_ch_q;
endmodule
`default_nettype wire

// File: tb/tb_tdm_fir_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tdm_fir_bank : randomized bench against a tap-sum reference model     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tdm_fir_bank;
  localparam int T     = 31;
  localparam int NCH   = 3;
  localparam int DEPTH = NCH * T;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_fir_bank_if #(.DATA_W(16), .COEF_W(16), .TAP_CNT(T), .CH_CNT(NCH), .GAIN_W(4)) bus ();

  tdm_fir_bank #(.DATA_W(16), .COEF_W(16), .TAP_CNT(T), .CH_CNT(NCH), .GAIN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     total = 0;
  int     bad   = 0;
  longint m_hist [NCH][T];
  longint m_act  [T];
  longint m_sh   [T];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < T; k++) m_hist[c][k] = 0;
    for (int k = 0; k < T; k++) begin
      m_act[k] = 0;
      m_sh[k]  = 0;
    end
  endfunction

  // y[n] = sum c[k]*x[n-k], rounded half up from Q15, clamped to 20 bits.
  function automatic longint model_push(int ch, longint x);
    longint acc, y;
    for (int k = T - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
    m_hist[ch][0] = x;
    acc = 0;
    for (int k = 0; k < T; k++) acc += m_hist[ch][k] * m_act[k];
    y = (acc + 16384) >>> 15;
    if (y > 524287)  y = 524287;
    if (y < -524288) y = -524288;
    return y;
  endfunction

  function automatic longint rnd16();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.coef_swap = 1'b0;
  endtask

  task automatic push_shadow();
    longint v;
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      v = m_sh[k];
      bus.coef_we   = 1'b1;
      bus.coef_addr = 5'(k);
      bus.coef_data = v[15:0];
    end
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  task automatic swap_idle();
    @(negedge clk);
    bus.coef_swap = 1'b1;
    @(negedge clk);
    bus.coef_swap = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < T; k++) m_act[k] = m_sh[k];
  endtask

  task automatic accept_in(input int ch, input longint x, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      to = 1'b1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'(ch);
    bus.in_data  = x[15:0];
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output longint d, output int ch, output bit to);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    to = !bus.out_valid;
    d  = longint'(bus.out_data);
    ch = int'(bus.out_ch);
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic xfer(input int ch, input longint x, output longint d, output int och,
                      output int lat, output bit to);
    bit t1, t2;
    accept_in(ch, x, t1);
    if (t1) begin
      to = 1'b1; d = 0; och = -1; lat = 0;
      return;
    end
    wait_out(lat, d, och, t2);
    if (!t2) take_out();
    to = t2;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.in_ready !== 1'b0)  begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_data !== 20'sd0 || bus.out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_regs: data %0d ch %0d want 0 0", bus.out_data, bus.out_ch); end
    total++; if (bus.err_ch !== 1'b0)    begin bad++; $display("FAIL reset_err_ch: got %b want 0", bus.err_ch); end
    rst = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== DEPTH) begin bad++; $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH); end
    model_reset();
  endtask

  task automatic test_impulse();
    longint d, e;
    int och, lat;
    bit to;
    for (int k = 0; k < T; k++) m_sh[k] = (k + 1) * 256;
    push_shadow();
    swap_idle();
    for (int i = 0; i < T; i++) begin
      e = model_push(0, (i == 0) ? 1000 : 0);
      xfer(0, (i == 0) ? 1000 : 0, d, och, lat, to);
      total++; if (to || d !== e || och !== 0) begin bad++; $display("FAIL impulse[%0d]: got %0d ch %0d to %b want %0d ch 0", i, d, och, to, e); end
      if (i == 0) begin
        total++; if (lat !== T + 2) begin bad++; $display("FAIL latency: got %0d want %0d", lat, T + 2); end
        total++; if (d !== 8) begin bad++; $display("FAIL impulse_first: got %0d want 8", d); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL out_valid_drop: got %b want 0", bus.out_valid); end
      end
      if (i == T - 1) begin
        total++; if (d !== 242) begin bad++; $display("FAIL impulse_last: got %0d want 242", d); end
      end
    end
  endtask

  task automatic test_isolation();
    longint d, e;
    int och, lat;
    bit to;
    for (int i = 0; i < T; i++) begin
      e = model_push(1, (i == 0) ? 1000 : 0);
      xfer(1, (i == 0) ? 1000 : 0, d, och, lat, to);
      total++; if (to || d !== e || och !== 1) begin bad++; $display("FAIL iso_ch1[%0d]: got %0d ch %0d want %0d ch 1", i, d, och, e); end
      e = model_push(2, 500);
      xfer(2, 500, d, och, lat, to);
      total++; if (to || d !== e || och !== 2) begin bad++; $display("FAIL iso_ch2[%0d]: got %0d ch %0d want %0d ch 2", i, d, och, e); end
    end
    total++; if (d !== 1938) begin bad++; $display("FAIL iso_settle: got %0d want 1938", d); end
  endtask

  task automatic test_saturation();
    longint d, e;
    int och, lat;
    bit to;
    for (int k = 0; k < T; k++) m_sh[k] = 32767;
    push_shadow();
    swap_idle();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < T; i++) begin
        e = model_push(0, (p == 0) ? 32767 : -32768);
        xfer(0, (p == 0) ? 32767 : -32768, d, och, lat, to);
        total++; if (to || d !== e) begin bad++; $display("FAIL sat[%0d][%0d]: got %0d want %0d", p, i, d, e); end
      end
      total++; if (d !== ((p == 0) ? 524287 : -524288)) begin bad++; $display("FAIL sat_final[%0d]: got %0d want %0d", p, d, (p == 0) ? 524287 : -524288); end
    end
  endtask

  task automatic test_backpressure();
    longint d0, d, e, e2, x;
    int och, lat;
    bit to, unstable;
    for (int k = 0; k < T; k++) m_sh[k] = rnd16();
    push_shadow();
    swap_idle();
    x = rnd16();
    e = model_push(0, x);
    accept_in(0, x, to);
    wait_out(lat, d0, och, to);
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'd1;
    bus.in_data  = 16'sd1234;
    unstable     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || longint'(bus.out_data) !== d0 || bus.in_ready !== 1'b0) unstable = 1'b1;
    end
    bus.in_valid = 1'b0;
    total++; if (to || unstable) begin bad++; $display("FAIL bp_hold: to %b unstable %b want 0 0", to, unstable); end
    total++; if (d0 !== e) begin bad++; $display("FAIL bp_value: got %0d want %0d", d0, e); end
    take_out();
    x  = rnd16();
    e2 = model_push(1, x);
    xfer(1, x, d, och, lat, to);
    total++; if (to || d !== e2) begin bad++; $display("FAIL bp_not_consumed: got %0d want %0d", d, e2); end
  endtask

  task automatic test_swap_mid();
    longint d, e, x;
    int och, lat;
    bit to;
    for (int k = 0; k < T; k++) m_sh[k] = rnd16();
    push_shadow();
    x = rnd16();
    e = model_push(2, x);
    accept_in(2, x, to);
    repeat (5) @(negedge clk);
    bus.coef_swap = 1'b1;
    @(negedge clk);
    bus.coef_swap = 1'b0;
    wait_out(lat, d, och, to);
    if (!to) take_out();
    total++; if (to || d !== e) begin bad++; $display("FAIL swap_old_bank: got %0d want %0d", d, e); end
    for (int k = 0; k < T; k++) m_act[k] = m_sh[k];
    x = rnd16();
    e = model_push(2, x);
    xfer(2, x, d, och, lat, to);
    total++; if (to || d !== e) begin bad++; $display("FAIL swap_new_bank: got %0d want %0d", d, e); end
  endtask

  task automatic test_bad_channel();
    longint d, e, x;
    int och, lat;
    bit to, spurious;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'd3;
    bus.in_data  = 16'sd4321;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++; if (bus.err_ch !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL err_pulse: err %b ready %b want 1 1", bus.err_ch, bus.in_ready); end
    @(negedge clk);
    total++; if (bus.err_ch !== 1'b0) begin bad++; $display("FAIL err_width: got %b want 0", bus.err_ch); end
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious) begin bad++; $display("FAIL err_no_output: got output want none"); end
    x = rnd16();
    e = model_push(0, x);
    xfer(0, x, d, och, lat, to);
    total++; if (to || d !== e) begin bad++; $display("FAIL err_after: got %0d want %0d", d, e); end
  endtask

  task automatic test_random();
    longint d, e, x;
    int och, lat, ch;
    bit to;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) begin
        for (int k = 0; k < T; k++) m_sh[k] = rnd16() / 4;
        push_shadow();
        swap_idle();
      end
      ch = $urandom_range(0, NCH - 1);
      x  = rnd16();
      e  = model_push(ch, x);
      accept_in(ch, x, to);
      if (!to) wait_out(lat, d, och, to);
      if (!to) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        take_out();
      end
      total++; if (to || d !== e || och !== ch) begin bad++; $display("FAIL random[%0d]: got %0d ch %0d want %0d ch %0d", i, d, och, e, ch); end
    end
  endtask

  task automatic test_reset_mid();
    longint d, e, x;
    int och, lat, n;
    bit to;
    accept_in(1, 777, to);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_now: valid %b ready %b want 0 0", bus.out_valid, bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== DEPTH) begin bad++; $display("FAIL rst_mid_clear: got %0d want %0d", n, DEPTH); end
    model_reset();
    for (int k = 0; k < T; k++) m_sh[k] = rnd16();
    push_shadow();
    swap_idle();
    for (int c = 0; c < 2; c++) begin
      x = rnd16();
      e = model_push(c, x);
      xfer(c, x, d, och, lat, to);
      total++; if (to || d !== e) begin bad++; $display("FAIL rst_mid_hist[%0d]: got %0d want %0d", c, d, e); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_isolation();
    test_saturation();
    test_backpressure();
    test_swap_mid();
    test_bad_channel();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
